// File: rtl/int_pkg.sv
// Shared definitions for the interrupt controller: cause codes, timer state, priority encoder.
// Latency: none (types, constants and pure functions only).
// Backpressure: not applicable.
package int_pkg;

    // Largest source vector: halt + timer + 16 external lines.
    localparam int MAX_SRC = 18;
    localparam int SRC_W   = 5;

    localparam logic [31:0] CAUSE_NONE  = 32'd0;
    localparam logic [31:0] CAUSE_HALT  = 32'd1;
    localparam logic [31:0] CAUSE_TIMER = 32'd2;

    typedef enum logic {
        TMR_IDLE = 1'b0,
        TMR_RUN  = 1'b1
    } tmr_state_t;

    // Index of the lowest set bit among the first n bits of req; 0 when none is set.
    // Callers pass a zero-extended vector and their real source count as n.
    function automatic logic [SRC_W-1:0] prio_enc(input logic [MAX_SRC-1:0] req, input int n);
        logic [SRC_W-1:0] idx;
        idx = '0;
        for (int i = MAX_SRC - 1; i >= 0; i--) begin
            if (i < n && req[i]) begin
                idx = SRC_W'(i);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/interrupt_controller_if.sv
// CPU-side bundle of the interrupt controller: requests, mask/ack control, PC redirect.
// Latency: wires only; take_int/pc_target are same-cycle, the rest are registered in the controller.
// Backpressure: none; the CPU must honour take_int in the cycle it is raised.
interface interrupt_controller_if #(
    parameter int NUM_IRQ     = 4,
    parameter int PC_WIDTH    = 11,
    parameter int TIMER_WIDTH = 16
);
    logic                   halt;
    logic                   set_timer;
    logic [TIMER_WIDTH-1:0] timer_value;
    logic [NUM_IRQ-1:0]     irq;
    logic                   mask_wr;
    logic [NUM_IRQ:0]       mask_data;
    logic                   ack;
    logic [PC_WIDTH-1:0]    pc_next;
    logic                   take_int;
    logic [PC_WIDTH-1:0]    pc_target;
    logic [PC_WIDTH-1:0]    pc_saved;
    logic [31:0]            cause;
    logic [NUM_IRQ+1:0]     pending;
    logic                   in_service;

    // master: the CPU side that raises requests and follows the PC redirect.
    modport master (
        output halt, set_timer, timer_value, irq, mask_wr, mask_data, ack, pc_next,
        input  take_int, pc_target, pc_saved, cause, pending, in_service
    );

    // slave: the interrupt controller itself.
    modport slave (
        input  halt, set_timer, timer_value, irq, mask_wr, mask_data, ack, pc_next,
        output take_int, pc_target, pc_saved, cause, pending, in_service
    );
endinterface

// File: rtl/int_timer.sv
// Down-counting interval timer; pulses expire on the cycle its count sits at 1.
// Latency: expire is raised exactly timer_value cycles after the load edge.
// Backpressure: none; a load on the expiry cycle wins and suppresses that expire pulse.
module int_timer
    import int_pkg::*;
#(
    parameter int TIMER_WIDTH = 16,
    parameter bit AUTO_RELOAD = 1'b0
) (
    input  logic                   Clock,
    input  logic                   Reset,
    input  logic                   set_timer,
    input  logic [TIMER_WIDTH-1:0] timer_value,
    output logic                   expire
);

    localparam logic [TIMER_WIDTH-1:0] ONE = TIMER_WIDTH'(1);

    tmr_state_t             state;
    logic [TIMER_WIDTH-1:0] count;
    logic [TIMER_WIDTH-1:0] reload;

    assign expire = (state == TMR_RUN) && (count == ONE) && !set_timer;

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state  <= TMR_IDLE;
            count  <= '0;
            reload <= '0;
        end else if (set_timer) begin
            // A zero load value stops the timer outright.
            if (timer_value != '0) begin
                state  <= TMR_RUN;
                count  <= timer_value;
                reload <= timer_value;
            end else begin
                state <= TMR_IDLE;
                count <= '0;
            end
        end else if (state == TMR_RUN) begin
            if (count == ONE) begin
                if (AUTO_RELOAD) begin
                    count <= reload;
                end else begin
                    state <= TMR_IDLE;
                    count <= '0;
                end
            end else begin
                count <= count - ONE;
            end
        end
    end

endmodule

// File: rtl/interrupt_controller.sv
// Priority interrupt controller: halt (NMI), timer and NUM_IRQ edge-triggered lines redirect the PC.
// Latency: requests latch one edge after they occur; take_int/pc_target are combinational from that state.
// Backpressure: one handler at a time; ack releases it, only halt may pre-empt an active handler.
// Ports: Clock, Reset (async, active-high), bus (interrupt_controller_if.slave).
module interrupt_controller
    import int_pkg::*;
#(
    parameter int                  NUM_IRQ     = 4,
    parameter int                  PC_WIDTH    = 11,
    parameter int                  TIMER_WIDTH = 16,
    parameter logic [PC_WIDTH-1:0] ISR_ADDR    = '0,
    parameter bit                  AUTO_RELOAD = 1'b0
) (
    input  logic                  Clock,
    input  logic                  Reset,
    interrupt_controller_if.slave bus
);

    localparam int NSRC = NUM_IRQ + 2;

    logic [NSRC-1:0]     pending_q;
    logic [NUM_IRQ:0]    enable_q;
    logic [NUM_IRQ-1:0]  irq_prev_q;
    logic                in_service_q;
    logic [31:0]         cause_q;
    logic [PC_WIDTH-1:0] pc_saved_q;

    logic                timer_expire;
    logic [NSRC-1:0]     eligible;
    logic [NSRC-1:0]     set_vec;
    logic [NSRC-1:0]     win_onehot;
    logic [NSRC-1:0]     pending_d;
    logic [SRC_W-1:0]    win_idx;
    logic                take;

    int_timer #(
        .TIMER_WIDTH (TIMER_WIDTH),
        .AUTO_RELOAD (AUTO_RELOAD)
    ) u_timer (
        .Clock       (Clock),
        .Reset       (Reset),
        .set_timer   (bus.set_timer),
        .timer_value (bus.timer_value),
        .expire      (timer_expire)
    );

    always_comb begin
        // Source 0 (halt) ignores both the enable register and in_service.
        eligible   = pending_q & {enable_q & {(NUM_IRQ + 1){~in_service_q}}, 1'b1};
        take       = |eligible;
        win_idx    = prio_enc(MAX_SRC'(eligible), NSRC);
        win_onehot = NSRC'(1) << win_idx;
        set_vec    = {bus.irq & ~irq_prev_q, timer_expire, bus.halt};
        // Clear the winner first, then OR in new requests so a fresh one is never lost.
        pending_d  = (pending_q & ~(take ? win_onehot : '0)) | set_vec;
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            pending_q    <= '0;
            enable_q     <= '0;
            irq_prev_q   <= '0;
            in_service_q <= 1'b0;
            cause_q      <= CAUSE_NONE;
            pc_saved_q   <= '0;
        end else begin
            pending_q  <= pending_d;
            irq_prev_q <= bus.irq;
            if (bus.mask_wr) begin
                enable_q <= bus.mask_data;
            end
            // A take (only possible under an active handler via halt) overrides ack.
            if (take) begin
                pc_saved_q   <= bus.pc_next;
                cause_q      <= 32'(win_idx) + 32'd1;
                in_service_q <= 1'b1;
            end else if (bus.ack && in_service_q) begin
                cause_q      <= CAUSE_NONE;
                in_service_q <= 1'b0;
            end
        end
    end

    assign bus.take_int   = take;
    assign bus.pc_target  = take ? ISR_ADDR : bus.pc_next;
    assign bus.pc_saved   = pc_saved_q;
    assign bus.cause      = cause_q;
    assign bus.pending    = pending_q;
    assign bus.in_service = in_service_q;

endmodule

// File: tb/tb_interrupt_controller.sv
// Self-checking bench for interrupt_controller: vector table plus multi-cycle sequences.
// Latency: checks combinational outputs in-cycle and registered outputs after each edge.
// Backpressure: a scoreboard queue holds the expected cause of every take the stimulus provokes.
module tb_interrupt_controller;
    import int_pkg::*;

    localparam logic [10:0] ISR = 11'h100;

    logic Clock = 1'b0;
    logic Reset = 1'b1;
    always #5 Clock = ~Clock;

    interrupt_controller_if #(.NUM_IRQ(4), .PC_WIDTH(11), .TIMER_WIDTH(16)) bus ();
    interrupt_controller_if #(.NUM_IRQ(4), .PC_WIDTH(11), .TIMER_WIDTH(16)) bus_ar ();

    interrupt_controller #(
        .NUM_IRQ(4), .PC_WIDTH(11), .TIMER_WIDTH(16), .ISR_ADDR(ISR), .AUTO_RELOAD(1'b0)
    ) dut (
        .Clock (Clock),
        .Reset (Reset),
        .bus   (bus)
    );

    interrupt_controller #(
        .NUM_IRQ(4), .PC_WIDTH(11), .TIMER_WIDTH(16), .ISR_ADDR(ISR), .AUTO_RELOAD(1'b1)
    ) dut_ar (
        .Clock (Clock),
        .Reset (Reset),
        .bus   (bus_ar)
    );

    typedef struct {
        logic        halt;
        logic [3:0]  irq;
        logic        mask_wr;
        logic [4:0]  mask_data;
        logic        ack;
        logic [10:0] pc;
        logic        exp_take;
        logic [31:0] push_cause;
        logic [10:0] exp_tgt;
        logic [5:0]  exp_pend;
        logic        exp_is;
        logic [31:0] exp_cause;
    } vec_t;

    vec_t vecs [17];
    int   tests = 0;
    int   fails = 0;
    int   exp_q [$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic cyc();
        @(posedge Clock);
        #1;
    endtask

    task automatic idle_inputs();
        bus.halt = 0;    bus.set_timer = 0;    bus.timer_value = '0;    bus.irq = '0;
        bus.mask_wr = 0; bus.mask_data = '0;   bus.ack = 0;             bus.pc_next = '0;
        bus_ar.halt = 0; bus_ar.set_timer = 0; bus_ar.timer_value = '0; bus_ar.irq = '0;
        bus_ar.mask_wr = 0; bus_ar.mask_data = '0; bus_ar.ack = 0;      bus_ar.pc_next = '0;
    endtask

    // Scoreboard consumer: every take must match a queued expectation.
    initial begin
        int          exp_c;
        logic [10:0] exp_pc;
        forever begin
            @(negedge Clock);
            if (!Reset && bus.take_int) begin
                exp_pc = bus.pc_next;
                if (exp_q.size() == 0) begin
                    check("take_expected", 32'(exp_q.size()), 32'd1);
                end else begin
                    exp_c = exp_q.pop_front();
                    @(posedge Clock);
                    #1;
                    check("take_cause", bus.cause, 32'(exp_c));
                    check("take_pc_saved", 32'(bus.pc_saved), 32'(exp_pc));
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int seen;
        //            halt irq     mw   md        ack pc  take push tgt  pend       is cause
        vecs[0]  = '{0, 4'b0000, 1, 5'b11111, 0, 10, 0, 0, 10,  6'b000000, 0, 0};
        vecs[1]  = '{0, 4'b0101, 0, 5'b00000, 0, 11, 0, 0, 11,  6'b000000, 0, 0};
        vecs[2]  = '{0, 4'b0101, 0, 5'b00000, 0, 12, 1, 3, ISR, 6'b010100, 0, 0};
        vecs[3]  = '{0, 4'b0101, 0, 5'b00000, 0, 13, 0, 0, 13,  6'b010000, 1, 3};
        vecs[4]  = '{0, 4'b0101, 0, 5'b00000, 1, 14, 0, 0, 14,  6'b010000, 1, 3};
        vecs[5]  = '{0, 4'b0101, 0, 5'b00000, 0, 15, 1, 5, ISR, 6'b010000, 0, 0};
        vecs[6]  = '{0, 4'b0100, 0, 5'b00000, 0, 16, 0, 0, 16,  6'b000000, 1, 5};
        vecs[7]  = '{0, 4'b0101, 0, 5'b00000, 0, 17, 0, 0, 17,  6'b000000, 1, 5};
        vecs[8]  = '{0, 4'b0101, 0, 5'b00000, 0, 18, 0, 0, 18,  6'b000100, 1, 5};
        vecs[9]  = '{0, 4'b0101, 1, 5'b11101, 1, 19, 0, 0, 19,  6'b000100, 1, 5};
        vecs[10] = '{0, 4'b0101, 0, 5'b00000, 0, 20, 0, 0, 20,  6'b000100, 0, 0};
        vecs[11] = '{0, 4'b0100, 0, 5'b00000, 0, 21, 0, 0, 21,  6'b000100, 0, 0};
        vecs[12] = '{0, 4'b0101, 0, 5'b00000, 0, 22, 0, 0, 22,  6'b000100, 0, 0};
        vecs[13] = '{0, 4'b0101, 1, 5'b11111, 0, 23, 0, 0, 23,  6'b000100, 0, 0};
        vecs[14] = '{0, 4'b0101, 0, 5'b00000, 0, 24, 1, 3, ISR, 6'b000100, 0, 0};
        vecs[15] = '{0, 4'b0101, 0, 5'b00000, 1, 25, 0, 0, 25,  6'b000000, 1, 3};
        vecs[16] = '{0, 4'b0000, 0, 5'b00000, 0, 26, 0, 0, 26,  6'b000000, 0, 0};

        idle_inputs();
        #3;
        check("rst_take", 32'(bus.take_int), 0);
        check("rst_pending", 32'(bus.pending), 0);
        check("rst_cause", bus.cause, 0);
        check("rst_in_service", 32'(bus.in_service), 0);
        check("rst_pc_saved", 32'(bus.pc_saved), 0);
        @(negedge Clock);
        Reset = 1'b0;
        cyc();

        // Priority, ack, nesting and mask behaviour.
        for (int i = 0; i < 17; i++) begin
            bus.halt      = vecs[i].halt;
            bus.irq       = vecs[i].irq;
            bus.mask_wr   = vecs[i].mask_wr;
            bus.mask_data = vecs[i].mask_data;
            bus.ack       = vecs[i].ack;
            bus.pc_next   = vecs[i].pc;
            #1;
            if (vecs[i].exp_take) exp_q.push_back(int'(vecs[i].push_cause));
            check($sformatf("vec%0d_take", i), 32'(bus.take_int), 32'(vecs[i].exp_take));
            check($sformatf("vec%0d_pc_target", i), 32'(bus.pc_target), 32'(vecs[i].exp_tgt));
            check($sformatf("vec%0d_pending", i), 32'(bus.pending), 32'(vecs[i].exp_pend));
            check($sformatf("vec%0d_in_service", i), 32'(bus.in_service), 32'(vecs[i].exp_is));
            check($sformatf("vec%0d_cause", i), bus.cause, vecs[i].exp_cause);
            cyc();
        end
        idle_inputs();

        // One-shot timer of 5: take lands 5 edges after the load edge.
        bus.set_timer = 1; bus.timer_value = 16'd5; bus.pc_next = 11'd30;
        cyc();
        bus.set_timer = 0; bus.timer_value = '0;
        for (int n = 0; n < 5; n++) begin
            bus.pc_next = 11'(31 + n);
            #1;
            check("timer_wait_take", 32'(bus.take_int), 0);
            cyc();
        end
        bus.pc_next = 11'd40;
        exp_q.push_back(int'(CAUSE_TIMER));
        #1;
        check("timer_take", 32'(bus.take_int), 1);
        check("timer_pending", 32'(bus.pending), 32'b000010);
        cyc();

        // Halt pre-empts the timer handler; ack in the take cycle loses.
        bus.halt = 1;
        #1;
        check("halt_pre_cause", bus.cause, CAUSE_TIMER);
        check("halt_pre_take", 32'(bus.take_int), 0);
        cyc();
        bus.halt = 0; bus.ack = 1; bus.pc_next = 11'd50;
        exp_q.push_back(int'(CAUSE_HALT));
        #1;
        check("halt_take", 32'(bus.take_int), 1);
        check("halt_pc_target", 32'(bus.pc_target), 32'(ISR));
        cyc();
        bus.ack = 0;
        #1;
        check("halt_over_ack_in_service", 32'(bus.in_service), 1);
        bus.ack = 1;
        cyc();
        bus.ack = 0;
        #1;
        check("ack_in_service", 32'(bus.in_service), 0);
        check("ack_cause", bus.cause, CAUSE_NONE);
        check("ack_take", 32'(bus.take_int), 0);

        // Reset mid-count with a masked irq[0] pending.
        bus.mask_wr = 1; bus.mask_data = 5'b11101;
        cyc();
        bus.mask_wr = 0; bus.irq = 4'b0001;
        cyc();
        bus.irq = 4'b0000; bus.set_timer = 1; bus.timer_value = 16'd10;
        cyc();
        bus.set_timer = 0; bus.timer_value = '0;
        #1;
        check("pre_rst_pending", 32'(bus.pending), 32'b000100);
        check("pre_rst_take", 32'(bus.take_int), 0);
        repeat (7) cyc();
        bus.pc_next = '0;
        #2;
        Reset = 1'b1;
        #1;
        check("midrst_take", 32'(bus.take_int), 0);
        check("midrst_pc_target", 32'(bus.pc_target), 0);
        check("midrst_pending", 32'(bus.pending), 0);
        check("midrst_cause", bus.cause, 0);
        check("midrst_in_service", 32'(bus.in_service), 0);
        check("midrst_pc_saved", 32'(bus.pc_saved), 0);
        cyc();
        cyc();
        @(negedge Clock);
        Reset = 1'b0;
        seen = 0;
        repeat (20) begin
            cyc();
            if (bus.take_int) seen++;
        end
        check("post_rst_takes", 32'(seen), 0);
        check("post_rst_pending", 32'(bus.pending), 0);

        // Auto-reload timer of 4, acknowledged each time.
        bus_ar.mask_wr = 1; bus_ar.mask_data = 5'b11111;
        cyc();
        bus_ar.mask_wr = 0; bus_ar.set_timer = 1; bus_ar.timer_value = 16'd4;
        cyc();
        bus_ar.set_timer = 0; bus_ar.timer_value = '0;
        for (int n = 0; n < 17; n++) begin
            bus_ar.ack = (n % 4 == 1);
            #1;
            check($sformatf("ar_take_n%0d", n), 32'(bus_ar.take_int), 32'(n > 0 && n % 4 == 0));
            cyc();
        end
        bus_ar.ack = 0;

        check("scoreboard_drained", 32'(exp_q.size()), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/interrupt_controller.md
INTERRUPT_CONTROLLER -- requirements
Module: interrupt_controller

Interface
REQ-001 Parameter NUM_IRQ, default 4: number of external interrupt lines, 1..16.
REQ-002 Parameter PC_WIDTH, default 11: instruction-address width.
REQ-003 Parameter TIMER_WIDTH, default 16: timer counter width.
REQ-004 Parameter ISR_ADDR, default 0: PC_WIDTH-bit handler entry address.
REQ-005 Parameter AUTO_RELOAD, default 0: 1 means the timer reloads on expiry; 0 means one-shot.
REQ-006 Clock  in  1: single clock, all state on its rising edge.
REQ-007 Reset  in  1: asynchronous, active-high.
REQ-008 halt  in  1: CPU halt request; this is source 0 and is non-maskable.
REQ-009 set_timer  in  1: load the timer from timer_value.
REQ-010 timer_value  in  TIMER_WIDTH: timer load value; 0 disables the timer.
REQ-011 irq  in  NUM_IRQ: external request levels, sources 2..NUM_IRQ+1.
REQ-012 mask_wr  in  1: write the enable register.
REQ-013 mask_data  in  NUM_IRQ+1: enables for sources 1..NUM_IRQ+1; bit 0 is the timer.
REQ-014 ack  in  1: handler done (getInterruption); clears the cause and the in-service flag.
REQ-015 pc_next  in  PC_WIDTH: PC the CPU would load this cycle.
REQ-016 take_int  out  1: combinational; this cycle's PC load is ISR_ADDR.
REQ-017 pc_target  out  PC_WIDTH: take_int ? ISR_ADDR : pc_next.
REQ-018 pc_saved  out  PC_WIDTH: pc_next captured at the last take.
REQ-019 cause  out  32: 0 = none, otherwise the winning source index + 1.
REQ-020 pending  out  NUM_IRQ+2: latched request bits, indexed by source.
REQ-021 in_service  out  1: a handler is active.

Function
REQ-022 Source priority is by index, lowest first: halt (0), timer (1), irq[0] (2), and so on.
REQ-023 halt sets pending[0] on every cycle it is high.
REQ-024 irq edges: a rising edge on irq[k] (registered previous level versus current) sets pending[k+2] at the next edge.
REQ-025 Masked sources: a masked source still latches pending, but is not eligible.
REQ-026 Eligibility:
- Source 0 is eligible when pending[0] is set, regardless of in_service.
- Any other source is eligible when pending & enable & !in_service.
REQ-027 take_int = any eligible source, evaluated from registered state only.
REQ-028 Effect of a take, at that edge:
- pc_saved <= pc_next.
- cause <= winning index + 1.
- in_service <= 1.
- The winner's pending bit clears.
- Other pending bits are held.
REQ-029 Set and clear of the same pending bit in one cycle: the new request wins and the bit stays set.
REQ-030 ack with in_service=1: cause <= 0 and in_service <= 0 at the edge; take_int stays blocked that cycle and a pending request is taken on the following cycle.
REQ-031 ack with in_service=0 has no effect.
REQ-032 ack and a take in the same cycle (halt only): the take wins.
REQ-033 Timer states are IDLE and RUN.
- set_timer with timer_value != 0: count <= timer_value and the state goes to RUN, from either state (a reload in RUN restarts the count).
- set_timer with timer_value = 0: the state goes to IDLE.
- In RUN, count decrements once per cycle.
- When count = 1: pending[1] sets, then count <= reload value if AUTO_RELOAD, otherwise the state goes to IDLE.
- Expiry therefore occurs exactly timer_value cycles after the load.
REQ-034 The timer keeps counting while in_service=1.
REQ-035 set_timer on the expiry cycle: the load wins and pending[1] does not set.
REQ-036 mask_wr takes effect from the next cycle; pending bits are unaffected.

Reset
REQ-037 While Reset is asserted, these are zero:
- pending, cause, in_service, pc_saved.
- The irq edge registers.
- The timer, which is IDLE with count 0.
- The enable register.
REQ-038 A reset mid-handler or mid-count discards all state, and take_int is 0 until new requests arrive.

Structure
REQ-039 The cause code constants (CAUSE_NONE=0, CAUSE_HALT=1, CAUSE_TIMER=2) and the timer-state encoding belong in a shared package, int_pkg.
REQ-040 The timer is a sub-module, int_timer (TIMER_WIDTH, AUTO_RELOAD), with a single expire output.
REQ-041 The priority encoder is a parameterised combinational function in int_pkg.

Verification
REQ-042 Timer: set_timer with timer_value=5 and enable=all -> take_int asserts 5 cycles later, cause=2, and pc_saved equals pc_next on the take cycle.
REQ-043 Priority:
- Stimulus: irq[0] and irq[2] both rise in the same cycle, all sources enabled.
- Required: cause=3 first.
- After ack: the next take has cause=5.
REQ-044 Nesting and mask:
- In service: an irq edge sets pending but take_int=0.
- Masked edge: with mask bit 1 cleared, an irq[0] edge gives pending[2]=1 and no take.
- Unmask: writing the bit to 1 gives a take one cycle later.
REQ-045 Halt pre-empts:
- Stimulus: halt asserts while in_service=1 with cause=2.
- Required: take_int=1, cause=1, pc_target=ISR_ADDR.
REQ-046 Reset mid-count:
- Stimulus: assert Reset with the timer at count 3 and pending=6'b000100.
- Required: all outputs 0 and no expiry afterwards.
- Stimulus: AUTO_RELOAD=1, timer_value=4.
- Required: a take every 4 cycles for as long as it is acknowledged.
